// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port unified instruction/data memory of the multi-cycle
// MIPS core between the CPU control path and the program loader / debug port.
// Each access is granted in IDLE, held on the memory for a fixed wait-state
// window (ACCESS), and finished with a one-cycle done pulse (DONE).
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : ties go to the requester that was not granted last time
//   undefined : fixed priority, the CPU always wins ties
//
// Parameters
//   AW          address width
//   DW          data width
//   WAIT_CYCLES cycles the memory strobe is held per access (>= 1)
//
// Ports
//   i_clk                  system clock, rising edge
//   i_rst                  synchronous active-high reset
//   i_cpu_req/we/addr/wdata CPU request, held high until o_cpu_done
//   o_cpu_rdata, o_cpu_done CPU registered read data and completion pulse
//   i_ldr_req/we/addr/wdata loader request, held high until o_ldr_done
//   o_ldr_rdata, o_ldr_done loader registered read data and completion pulse
//   o_mem_addr, o_mem_wdata memory address / write data (stable during ACCESS)
//   o_mem_re, o_mem_we      memory read / write strobes
//   i_mem_rdata             memory read data, valid on the last ACCESS cycle
//   o_busy                  high in ACCESS and DONE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_done,
  input  logic          i_ldr_req,
  input  logic          i_ldr_we,
  input  logic [AW-1:0] i_ldr_addr,
  input  logic [DW-1:0] i_ldr_wdata,
  output logic [DW-1:0] o_ldr_rdata,
  output logic          o_ldr_done,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_re,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;

  state_t          r_state;
  owner_t          r_owner;
  logic            r_we;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_mem_re;
  logic            r_mem_we;
  logic [DW-1:0]   r_cpu_rdata;
  logic [DW-1:0]   r_ldr_rdata;
  logic            r_cpu_done;
  logic            r_ldr_done;
  logic            r_busy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t          r_last_owner;
`endif

  owner_t          w_grant;
  logic            w_any_req;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  assign w_any_req = i_cpu_req | i_ldr_req;

  // Grant selection. A lone requester always wins; only ties depend on policy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_grant = OWN_CPU;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_cpu_req && i_ldr_req) begin
      w_grant = (r_last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (i_ldr_req) begin
      w_grant = OWN_LDR;
    end
`else
    if (!i_cpu_req && i_ldr_req) begin
      w_grant = OWN_LDR;
    end
`endif
  end

  always_comb begin
    w_sel_we    = i_cpu_we;
    w_sel_addr  = i_cpu_addr;
    w_sel_wdata = i_cpu_wdata;
    if (w_grant == OWN_LDR) begin
      w_sel_we    = i_ldr_we;
      w_sel_addr  = i_ldr_addr;
      w_sel_wdata = i_ldr_wdata;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_cpu_done  <= 1'b0;
      r_ldr_done  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_owner <= OWN_LDR;
`endif
    end else begin
      r_cpu_done <= 1'b0;
      r_ldr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Everything the access needs is latched here; requester inputs
            // are ignored until the FSM is back in IDLE.
            r_owner     <= w_grant;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_re    <= ~w_sel_we;
            r_mem_we    <= w_sel_we;
            r_cnt       <= CW'(WAIT_CYCLES - 1);
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_owner <= w_grant;
`endif
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            // Last wait-state cycle: memory data is valid now.
            if (!r_we) begin
              if (r_owner == OWN_LDR) r_ldr_rdata <= i_mem_rdata;
              else                    r_cpu_rdata <= i_mem_rdata;
            end
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_done <= (r_owner == OWN_CPU);
            r_ldr_done <= (r_owner == OWN_LDR);
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_ldr_rdata = r_ldr_rdata;
  assign o_cpu_done  = r_cpu_done;
  assign o_ldr_done  = r_ldr_done;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Transaction-level model: at each clock edge the model decides, from the
// arbitration rules alone, whether an access is granted and to whom, and
// pushes the expected completion into a scoreboard queue. A monitor on the
// falling edge pops the queue when a done pulse appears and also checks the
// memory-side strobes against the window the model predicts.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic          cpu_done, ldr_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_re, mem_we, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_done(cpu_done),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr),
    .i_ldr_wdata(ldr_wdata), .o_ldr_rdata(ldr_rdata), .o_ldr_done(ldr_done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_re(mem_re),
    .o_mem_we(mem_we), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  typedef struct {
    bit          ldr;
    bit          we;
    logic [31:0] data;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] phys_mem  [logic [31:0]];

  // Model state: the one access in flight, when the port is free again, and
  // the read data each requester should currently see.
  bit          act_valid = 0;
  int          act_g = 0;
  bit          act_ldr = 0, act_we = 0;
  logic [31:0] act_addr = 0, act_wdata = 0, act_rd = 0;
  int          next_free = 0;
  bit          last_ldr = 1;
  logic [31:0] exp_rd_cpu = 0, exp_rd_ldr = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  function logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  function logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, evaluated at each rising edge on the inputs just sampled.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        act_valid  = 0;
        sb_q.delete();
        next_free  = cyc + 1;
        last_ldr   = 1;
        exp_rd_cpu = '0;
        exp_rd_ldr = '0;
      end else begin
        if (act_valid && !act_we && cyc == act_g + W) begin
          if (act_ldr) exp_rd_ldr = act_rd;
          else         exp_rd_cpu = act_rd;
        end
        if (cyc >= next_free && (cpu_req || ldr_req)) begin
          bit g_ldr;
          if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            g_ldr = !last_ldr;
`else
            g_ldr = 0;
`endif
          end else begin
            g_ldr = ldr_req;
          end
          last_ldr  = g_ldr;
          act_valid = 1;
          act_g     = cyc;
          act_ldr   = g_ldr;
          act_we    = g_ldr ? ldr_we    : cpu_we;
          act_addr  = g_ldr ? ldr_addr  : cpu_addr;
          act_wdata = g_ldr ? ldr_wdata : cpu_wdata;
          next_free = cyc + W + 2;
          if (act_we) model_mem[act_addr] = act_wdata;
          act_rd = model_rd(act_addr);
          sb_q.push_back('{g_ldr, act_we, act_rd, cyc + W + 1});
        end
      end
      cyc++;
    end
  end

  // Monitor: memory-side behaviour, scoreboard pops, and the memory itself.
  initial begin
    mem_rdata = '0;
    forever begin
      int c;
      bit in_acc, in_done;
      @(negedge clk);
      c = cyc;
      if (c >= 1) begin
        if (mem_we) phys_mem[mem_addr] = mem_wdata;
        in_acc  = act_valid && c >= act_g + 1 && c <= act_g + W;
        in_done = act_valid && c == act_g + W + 1;
        check("busy",     busy,     in_acc || in_done);
        check("mem_re",   mem_re,   in_acc && !act_we);
        check("mem_we",   mem_we,   in_acc && act_we);
        check("cpu_done", cpu_done, in_done && !act_ldr);
        check("ldr_done", ldr_done, in_done && act_ldr);
        if (in_acc) begin
          check("mem_addr", mem_addr, act_addr);
          if (act_we) check("mem_wdata", mem_wdata, act_wdata);
        end
        check("cpu_rdata", cpu_rdata, exp_rd_cpu);
        check("ldr_rdata", ldr_rdata, exp_rd_ldr);

        if (cpu_done || ldr_done) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected_done: got done with empty queue (cycle %0d)", c);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_owner", ldr_done, e.ldr);
            check("sb_cycle", c, e.done_cyc);
            if (!e.we) check("sb_rdata", e.ldr ? ldr_rdata : cpu_rdata, e.data);
          end
        end else if (sb_q.size() > 0 && c > sb_q[0].done_cyc) begin
          checks++; failures++;
          $display("FAIL sb_timeout: got no done, required by cycle %0d (cycle %0d)",
                   sb_q[0].done_cyc, c);
          void'(sb_q.pop_front());
        end

        // Valid data only on the last wait-state cycle; noise otherwise.
        if (act_valid && c == act_g + W) mem_rdata = phys_rd(mem_addr);
        else                             mem_rdata = $urandom;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_fields(output logic we, output logic [31:0] addr, output logic [31:0] wdata);
    we    = 1'($urandom_range(0, 1));
    addr  = 32'($urandom_range(0, 15)) << 2;
    wdata = $urandom;
  endtask

  task automatic drive_req(input logic done, inout logic req, inout logic we,
                           inout logic [31:0] addr, inout logic [31:0] wdata);
    if (req) begin
      if (done) begin
        if ($urandom_range(0, 2) != 0) req = 1'b0;
        else rand_fields(we, addr, wdata);
      end else begin
        int r;
        r = int'($urandom_range(0, 31));
        if (r == 0)     req = 1'b0;
        else if (r < 4) rand_fields(we, addr, wdata);
      end
    end else if ($urandom_range(0, 3) == 0) begin
      req = 1'b1;
      rand_fields(we, addr, wdata);
    end
  endtask

  // Wait for a done pulse from one requester, bounded.
  task automatic wait_done(input bit ldr, input string name, output int re_n, output int we_n);
    bit seen;
    seen = 0;
    re_n = 0;
    we_n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_re) re_n++;
      if (mem_we) we_n++;
      if (ldr ? ldr_done : cpu_done) seen = 1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s: got no done within 20 cycles, required one", name);
    end
  endtask

  initial begin
    int re_n, we_n, n_cpu, n_ldr;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    repeat (3) tick();
    check("rst_mem_addr",  mem_addr,  '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_busy",      busy,      0);
    rst = 1'b0;
    tick();

    // CPU read of a preloaded word.
    model_mem[32'h40] = 32'hDEADBEEF;
    phys_mem[32'h40]  = 32'hDEADBEEF;
    cpu_we = 0; cpu_addr = 32'h40; cpu_req = 1;
    wait_done(0, "cpu_read", re_n, we_n);
    check("cpu_read_data", cpu_rdata, 32'hDEADBEEF);
    check("cpu_read_ldr_untouched", ldr_rdata, 32'h0);
    check("cpu_read_re_cycles", re_n, W);
    cpu_req = 0;
    tick();

    // Loader write.
    ldr_we = 1; ldr_addr = 32'h10; ldr_wdata = 32'h1234; ldr_req = 1;
    wait_done(1, "ldr_write", re_n, we_n);
    check("ldr_write_we_cycles", we_n, W);
    check("ldr_write_re_cycles", re_n, 0);
    ldr_req = 0;
    tick();

    // Both requesting continuously.
    cpu_we = 0; cpu_addr = 32'h40; ldr_we = 0; ldr_addr = 32'h10;
    cpu_req = 1; ldr_req = 1;
    n_cpu = 0; n_ldr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_done) n_cpu++;
      if (ldr_done) n_ldr++;
    end
    cpu_req = 0; ldr_req = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("tie_cpu_grants", n_cpu, 2);
    check("tie_ldr_grants", n_ldr, 1);
`else
    check("tie_cpu_grants", n_cpu, 3);
    check("tie_ldr_grants", n_ldr, 0);
`endif
    repeat (W + 3) tick();

    // Reset during the first ACCESS cycle of a write, then a fresh request.
    cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'hA5A5_5A5A; cpu_req = 1;
    tick();
    check("abort_we_before", mem_we, 1);
    rst = 1; cpu_req = 0;
    tick();
    check("abort_we_after", mem_we, 0);
    check("abort_busy", busy, 0);
    check("abort_no_done", cpu_done, 0);
    rst = 0;
    cpu_we = 0; cpu_req = 1;
    tick();
    check("post_reset_grant", busy, 1);
    wait_done(0, "post_reset_read", re_n, we_n);
    cpu_req = 0;
    tick();

    // Request dropped after the first cycle still completes once.
    cpu_we = 0; cpu_addr = 32'h44; cpu_req = 1;
    tick();
    cpu_req = 0;
    n_cpu = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_done) n_cpu++;
    end
    check("drop_single_done", n_cpu, 1);

    // Randomised traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      logic cd, ld;
      tick();
      cd = cpu_done;
      ld = ldr_done;
      rst = ($urandom_range(0, 199) == 0);
      drive_req(cd, cpu_req, cpu_we, cpu_addr, cpu_wdata);
      drive_req(ld, ldr_req, ldr_we, ldr_addr, ldr_wdata);
    end
    rst = 0; cpu_req = 0; ldr_req = 0;
    repeat (W + 5) tick();
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
